// File: rtl/sort_sched.sv
// sort_sched: shares one external 4-key descending sorter between NREQ requesters.
//
// A round-robin arbiter picks one pending requester while IDLE and pulses its
// req_ready. The job's keys are loaded into the sorter with a one-cycle sort_rdy
// strobe. The block then waits SORT_LAT cycles, captures the sorter bus and
// returns it with the winner's ID on a valid/ready response channel. Only one
// job is in flight at a time.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   req_valid  [NREQ]      request pending per requester
//   req_data   [NREQ*DW]   packed keys per requester, [7:6]=key1 .. [1:0]=key4
//   req_ready  [NREQ]      one-hot accept pulse to the granted requester
//   rsp_valid  result available
//   rsp_id     [IDW]       requester that owns the result
//   rsp_data   [DW]        sorted word, [7:6] largest .. [1:0] smallest
//   rsp_ready  response consumer accepts
//   sort_rdy   sorter load strobe
//   dat1..dat4 [2] each    keys to the sorter
//   sort       [DW]        sorter result bus
//   busy       high whenever a job is in progress
module sort_sched #(
    parameter int NREQ     = 2,
    parameter int DW       = 8,
    parameter int SORT_LAT = 2,
    parameter int IDW      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_data,
    input  logic               rsp_ready,
    output logic               sort_rdy,
    output logic [1:0]         dat1,
    output logic [1:0]         dat2,
    output logic [1:0]         dat3,
    output logic [1:0]         dat4,
    input  logic [DW-1:0]      sort,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       ptr_nxt_s;
    logic [IDW-1:0]       id_r;
    logic [7:0]           cnt_r;
    logic [2*NREQ-1:0]    dbl_s;
    logic [NREQ-1:0]      rot_s;
    logic                 gnt_found_s;
    logic [IDW-1:0]       gnt_idx_s;
    logic [NREQ-1:0]      gnt_onehot_s;
    logic [DW-1:0]        gnt_data_s;

    // Round-robin search: rotate requests so bit 0 is the current pointer,
    // then take the first set bit and map it back to a requester index.
    always_comb begin
        dbl_s       = {req_valid, req_valid};
        rot_s       = NREQ'(dbl_s >> ptr_r);
        gnt_found_s = 1'b0;
        gnt_idx_s   = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_s && rot_s[i]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = IDW'((int'(ptr_r) + i) % NREQ);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Decode the winner into a one-hot vector and select its key slice.
    always_comb begin
        gnt_onehot_s = {NREQ{1'b0}};
        gnt_data_s   = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_found_s && (gnt_idx_s == IDW'(i))) begin
                gnt_onehot_s[i] = 1'b1;
                gnt_data_s      = req_data[i*DW +: DW];
            end else begin
                gnt_onehot_s[i] = 1'b0;
            end
        end
        if (gnt_idx_s == IDW'(NREQ - 1)) begin
            ptr_nxt_s = {IDW{1'b0}};
        end else begin
            ptr_nxt_s = gnt_idx_s + IDW'(1);
        end
    end

    // The accept pulse must land in the grant cycle itself, so it is decoded
    // from the state register; gating with rst_n keeps it quiet during reset.
    always_comb begin
        if (rst_n && (state_r == S_IDLE)) begin
            req_ready = gnt_onehot_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (gnt_found_s) begin
                    state_nxt_s = S_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (cnt_r == 8'd1) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, arbitration pointer, latched job, latency counter and the
    // registered outputs (decoded from the next state so they align with it).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            ptr_r     <= {IDW{1'b0}};
            id_r      <= {IDW{1'b0}};
            cnt_r     <= 8'd0;
            busy      <= 1'b0;
            sort_rdy  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= {IDW{1'b0}};
            rsp_data  <= {DW{1'b0}};
            dat1      <= 2'd0;
            dat2      <= 2'd0;
            dat3      <= 2'd0;
            dat4      <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            busy      <= (state_nxt_s != S_IDLE);
            sort_rdy  <= (state_nxt_s == S_ISSUE);
            rsp_valid <= (state_nxt_s == S_RESP);
            if ((state_r == S_IDLE) && gnt_found_s) begin
                // Keys go straight into the sorter-facing registers and stay
                // there untouched until the next grant.
                dat1  <= gnt_data_s[7:6];
                dat2  <= gnt_data_s[5:4];
                dat3  <= gnt_data_s[3:2];
                dat4  <= gnt_data_s[1:0];
                id_r  <= gnt_idx_s;
                ptr_r <= ptr_nxt_s;
            end
            if (state_r == S_ISSUE) begin
                cnt_r <= 8'(SORT_LAT);
            end else if (state_r == S_WAIT) begin
                cnt_r <= cnt_r - 8'd1;
            end
            if ((state_r == S_WAIT) && (cnt_r == 8'd1)) begin
                rsp_data <= sort;
                rsp_id   <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_sort_sched.sv
// Self-checking bench for sort_sched with a behavioural fixed-latency sorter.
module tb_sort_sched;

    localparam int NREQ     = 2;
    localparam int DW       = 8;
    localparam int SORT_LAT = 2;
    localparam int IDW      = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               rsp_ready;
    logic               sort_rdy;
    logic [1:0]         dat1, dat2, dat3, dat4;
    logic [DW-1:0]      sort;
    logic               busy;

    logic [DW-1:0]      st [SORT_LAT];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q[$];
    int grant_log[$];
    int last_grant_cyc = -1;
    int last_hs_cyc = -1;
    int sort_rdy_cyc = -1;
    int sort_rdy_cnt = 0;
    int rsp_rise_cyc = -1;
    int last_rsp_data = -1;
    logic prev_rv = 1'b0;
    logic [NREQ-1:0] clr_mask = '0;
    bit auto_reload = 1'b0;

    always #5 clk = ~clk;

    sort_sched #(.NREQ(NREQ), .DW(DW), .SORT_LAT(SORT_LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .sort_rdy(sort_rdy),
        .dat1(dat1), .dat2(dat2), .dat3(dat3), .dat4(dat4),
        .sort(sort), .busy(busy)
    );

    // Reference descending sort of four 2-bit keys.
    function automatic logic [7:0] sort4(input logic [7:0] w);
        logic [1:0] k [4];
        logic [1:0] t;
        k[0] = w[7:6]; k[1] = w[5:4]; k[2] = w[3:2]; k[3] = w[1:0];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (k[j] < k[j+1]) begin
                    t = k[j]; k[j] = k[j+1]; k[j+1] = t;
                end
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // Sorter model: result appears SORT_LAT edges after the load cycle closes.
    always @(posedge clk) begin
        if (sort_rdy === 1'b1) st[0] <= sort4({dat1, dat2, dat3, dat4});
        for (int i = 1; i < SORT_LAT; i++) st[i] <= st[i-1];
    end
    assign sort = st[SORT_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe just before the edge, release granted requests after it.
    task automatic step();
        int e;
        @(negedge clk);
        #3;
        if (req_ready !== '0) begin
            check("grant_onehot", $countones(req_ready), 1);
            for (int r = 0; r < NREQ; r++) begin
                if (req_ready[r] === 1'b1) begin
                    exp_q.push_back(r * 256 + int'(sort4(req_data[r*DW +: DW])));
                    grant_log.push_back(r);
                    last_grant_cyc = cyc;
                    clr_mask[r] = 1'b1;
                end
            end
        end
        if (sort_rdy === 1'b1) begin
            sort_rdy_cyc = cyc;
            sort_rdy_cnt++;
        end
        if (rsp_valid === 1'b1 && prev_rv !== 1'b1) rsp_rise_cyc = cyc;
        prev_rv = rsp_valid;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            last_hs_cyc = cyc;
            last_rsp_data = int'(rsp_data);
            check("rsp_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_id", rsp_id, e / 256);
                check("rsp_data", rsp_data, e % 256);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (clr_mask[r]) begin
                if (auto_reload) req_data[r*DW +: DW] = 8'($urandom);
                else req_valid[r] = 1'b0;
            end
        end
        clr_mask = '0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (req_valid == '0 && exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        check("idle_reached", done, 1);
    endtask

    logic [7:0] t5_in  [3] = '{8'h00, 8'hFF, 8'h1B};
    logic [7:0] t5_exp [3] = '{8'h00, 8'hFF, 8'hE4};

    initial begin
        int g0;
        rst_n = 1'b0;
        req_valid = '1;
        req_data = {8'hD8, 8'hD8};
        rsp_ready = 1'b0;

        // Reset with all requests pending
        step();
        step();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        check("rst_sorter", {sort_rdy, dat1, dat2, dat3, dat4}, 0);
        check("rst_busy", busy, 0);
        check("rst_no_grant", grant_log.size(), 0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        // Single job, latency
        req_data[7:0] = 8'hD8;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        sort_rdy_cnt = 0;
        g0 = grant_log.size();
        wait_idle(40);
        check("t2_grants", grant_log.size() - g0, 1);
        check("t2_grant_id", grant_log[g0], 0);
        check("t2_sort_rdy_cyc", sort_rdy_cyc, last_grant_cyc + 1);
        check("t2_sort_rdy_cnt", sort_rdy_cnt, 1);
        check("t2_rsp_latency", rsp_rise_cyc, last_grant_cyc + SORT_LAT + 2);
        check("t2_data", last_rsp_data, 8'hE4);

        // Round-robin with both requesters held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        g0 = grant_log.size();
        auto_reload = 1'b1;
        req_data = 16'($urandom);
        req_valid = 2'b11;
        for (int i = 0; i < 60 && grant_log.size() < g0 + 4; i++) step();
        auto_reload = 1'b0;
        req_valid = '0;
        wait_idle(30);
        check("t3_grants", grant_log.size() - g0, 4);
        for (int k = 0; k < 4; k++) check("t3_order", grant_log[g0 + k], k % 2);

        // Backpressure in RESP
        rsp_ready = 1'b0;
        req_data[15:8] = 8'h4D;
        req_valid = 2'b10;
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) step();
        check("t4_rsp_seen", rsp_valid, 1);
        req_data[7:0] = 8'h5A;
        req_valid[0] = 1'b1;
        g0 = grant_log.size();
        repeat (5) begin
            step();
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_data", rsp_data, 8'hD4);
            check("t4_hold_id", rsp_id, 1);
            check("t4_no_grant", grant_log.size() - g0, 0);
        end
        rsp_ready = 1'b1;
        step();
        step();
        check("t4_regrant_gap", last_grant_cyc - last_hs_cyc, 1);
        check("t4_regrant_id", grant_log[grant_log.size() - 1], 0);
        wait_idle(30);

        // Edge key patterns
        for (int k = 0; k < 3; k++) begin
            req_data[7:0] = t5_in[k];
            req_valid = 2'b01;
            wait_idle(30);
            check("t5_data", last_rsp_data, t5_exp[k]);
        end

        // Reset in the middle of a job
        req_data[7:0] = 8'h27;
        req_valid = 2'b01;
        g0 = grant_log.size();
        for (int i = 0; i < 10 && grant_log.size() == g0; i++) step();
        step();
        rst_n = 1'b0;
        req_data = {8'h6C, 8'h93};
        req_valid = 2'b11;
        step();
        step();
        exp_q.delete();
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_busy", busy, 0);
        rst_n = 1'b1;
        g0 = grant_log.size();
        for (int i = 0; i < 10 && grant_log.size() == g0; i++) step();
        check("t6_regrants", grant_log.size() - g0, 1);
        check("t6_regrant_id", grant_log[g0], 0);
        wait_idle(60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
